// File: rtl/uart_wr_arbiter.sv
// rtl/uart_wr_arbiter.sv - two-master round-robin AXI4-Lite write arbiter for the UART slave
// One transaction in flight; grant held from arbitration until the B handshake.
module uart_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [2*ADDR_W-1:0]     i_m_awaddr,
    input  logic [1:0]              i_m_awvalid,
    output logic [1:0]              o_m_awready,
    input  logic [2*DATA_W-1:0]     i_m_wdata,
    input  logic [2*DATA_W/8-1:0]   i_m_wstrb,
    input  logic [1:0]              i_m_wvalid,
    output logic [1:0]              o_m_wready,
    output logic [3:0]              o_m_bresp,
    output logic [1:0]              o_m_bvalid,
    input  logic [1:0]              i_m_bready,
    output logic [ADDR_W-1:0]       o_s_awaddr,
    output logic                    o_s_awvalid,
    input  logic                    i_s_awready,
    output logic [DATA_W-1:0]       o_s_wdata,
    output logic [DATA_W/8-1:0]     o_s_wstrb,
    output logic                    o_s_wvalid,
    input  logic                    i_s_wready,
    input  logic [1:0]              i_s_bresp,
    input  logic                    i_s_bvalid,
    output logic                    o_s_bready
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1, ST_RESP = 2'd2} state_t;

    state_t     state_q, state_d;
    logic       g_q, g_d;
    logic       p_q, p_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] req;
    logic       aw_hs, w_hs;

    assign req = i_m_awvalid | i_m_wvalid;

    // Data path follows the grant unconditionally; valids qualify it.
    assign o_s_awaddr = g_q ? i_m_awaddr[ADDR_W +: ADDR_W] : i_m_awaddr[0 +: ADDR_W];
    assign o_s_wdata  = g_q ? i_m_wdata[DATA_W +: DATA_W]  : i_m_wdata[0 +: DATA_W];
    assign o_s_wstrb  = g_q ? i_m_wstrb[STRB_W +: STRB_W]  : i_m_wstrb[0 +: STRB_W];

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        p_d         = p_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_bvalid  = '0;
        o_m_bresp   = '0;
        o_s_awvalid = 1'b0;
        o_s_wvalid  = 1'b0;
        o_s_bready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    g_d       = req[p_q] ? p_q : ~p_q;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                o_s_awvalid        = i_m_awvalid[g_q] & ~aw_done_q;
                o_m_awready[g_q]   = i_s_awready & ~aw_done_q;
                o_s_wvalid         = i_m_wvalid[g_q] & ~w_done_q;
                o_m_wready[g_q]    = i_s_wready & ~w_done_q;
                aw_hs              = i_m_awvalid[g_q] & i_s_awready & ~aw_done_q;
                w_hs               = i_m_wvalid[g_q] & i_s_wready & ~w_done_q;
                aw_done_d          = aw_done_q | aw_hs;
                w_done_d           = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_m_bvalid[g_q]            = i_s_bvalid;
                o_m_bresp[{g_q, 1'b0} +: 2] = i_s_bresp;
                o_s_bready                 = i_m_bready[g_q];
                if (i_s_bvalid && i_m_bready[g_q]) begin
                    p_d     = ~g_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            g_q       <= 1'b0;
            p_q       <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            p_q       <= p_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_uart_wr_arbiter.sv
// tb/tb_uart_wr_arbiter.sv - directed self-checking bench for uart_wr_arbiter
module tb_uart_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] m_awaddr = '0;
    logic [1:0]  m_awvalid = '0;
    logic [1:0]  m_awready;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wstrb = '0;
    logic [1:0]  m_wvalid = '0;
    logic [1:0]  m_wready;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready = '0;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready = 1'b1;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready = 1'b1;
    logic [1:0]  s_bresp = '0;
    logic        s_bvalid = 1'b0;
    logic        s_bready;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [31:0] wq[$];

    uart_wr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_m_awaddr(m_awaddr), .i_m_awvalid(m_awvalid), .o_m_awready(m_awready),
        .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb), .i_m_wvalid(m_wvalid), .o_m_wready(m_wready),
        .o_m_bresp(m_bresp), .o_m_bvalid(m_bvalid), .i_m_bready(m_bready),
        .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wvalid(s_wvalid), .i_s_wready(s_wready),
        .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && s_wvalid && s_wready) begin
            wr_count <= wr_count + 1;
            wq.push_back(s_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
        checks++; if (dut.p_q !== 1'b0) begin errors++; $display("FAIL reset_p: got %b expected 0", dut.p_q); end
        checks++; if ({s_awvalid, s_wvalid, s_bready} !== 3'b000) begin errors++; $display("FAIL reset_s_ctl: got %b expected 000", {s_awvalid, s_wvalid, s_bready}); end
        checks++; if ({m_awready, m_wready, m_bvalid, m_bresp} !== 10'd0) begin errors++; $display("FAIL reset_m_out: got %h expected 0", {m_awready, m_wready, m_bvalid, m_bresp}); end
    endtask

    task automatic test_single();
        m_awaddr = {32'h0, 32'h1000_0000};
        m_wdata  = {32'h0, 32'h41};
        m_wstrb  = 8'h0F;
        m_bready = 2'b11;
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        settle();
        checks++; if (s_awvalid !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", s_awvalid); end
        tick();
        checks++; if ({s_awvalid, s_wvalid} !== 2'b11) begin errors++; $display("FAIL single_s_valid: got %b expected 11", {s_awvalid, s_wvalid}); end
        checks++; if (s_awaddr !== 32'h1000_0000) begin errors++; $display("FAIL single_awaddr: got %h expected 10000000", s_awaddr); end
        checks++; if (s_wdata !== 32'h41 || s_wstrb !== 4'hF) begin errors++; $display("FAIL single_wdata: got %h/%h expected 41/f", s_wdata, s_wstrb); end
        checks++; if ({m_awready, m_wready} !== 4'b0101) begin errors++; $display("FAIL single_m_ready: got %b expected 0101", {m_awready, m_wready}); end
        tick();
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        s_bresp   = 2'b00;
        s_bvalid  = 1'b1;
        settle();
        checks++; if (m_bvalid !== 2'b01 || m_bresp !== 4'b0000) begin errors++; $display("FAIL single_b: got %b/%b expected 01/0000", m_bvalid, m_bresp); end
        checks++; if (s_bready !== 1'b1 || s_awvalid !== 1'b0) begin errors++; $display("FAIL single_resp_ctl: got %b%b expected 10", s_bready, s_awvalid); end
        tick();
        s_bvalid = 1'b0;
        settle();
        checks++; if (dut.state_q !== 2'd0 || m_bvalid !== 2'b00) begin errors++; $display("FAIL single_idle: got %0d/%b expected 0/00", dut.state_q, m_bvalid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wq.delete();
        m_awaddr  = {32'h2000_0004, 32'h2000_0000};
        m_wdata   = {32'h42, 32'h41};
        m_bready  = 2'b11;
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        tick();
        checks++; if (s_wdata !== 32'h41 || m_awready !== 2'b01) begin errors++; $display("FAIL simul_first: got %h/%b expected 41/01", s_wdata, m_awready); end
        tick();
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        s_bvalid  = 1'b1;
        settle();
        checks++; if (m_bvalid !== 2'b01 || m_awready !== 2'b00 || s_awvalid !== 1'b0) begin errors++; $display("FAIL simul_m1_stall: got %b/%b/%b expected 01/00/0", m_bvalid, m_awready, s_awvalid); end
        tick();
        s_bvalid = 1'b0;
        settle();
        checks++; if (s_awvalid !== 1'b0) begin errors++; $display("FAIL simul_gap: got %b expected 0", s_awvalid); end
        tick();
        checks++; if (s_wdata !== 32'h42 || s_awaddr !== 32'h2000_0004 || m_awready !== 2'b10) begin errors++; $display("FAIL simul_second: got %h/%h/%b expected 42/20000004/10", s_wdata, s_awaddr, m_awready); end
        tick();
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        s_bvalid  = 1'b1;
        settle();
        checks++; if (m_bvalid !== 2'b10) begin errors++; $display("FAIL simul_b1: got %b expected 10", m_bvalid); end
        tick();
        s_bvalid = 1'b0;
        settle();
        checks++; if (dut.p_q !== 1'b0) begin errors++; $display("FAIL simul_p_end: got %b expected 0", dut.p_q); end
        checks++; if (wq.size() != 2 || wq[0] !== 32'h41 || wq[1] !== 32'h42) begin errors++; $display("FAIL simul_order: got %0d writes expected 41 then 42", wq.size()); end
    endtask

    task automatic test_w_first();
        int base;
        base = wr_count;
        m_wdata  = {32'h77, 32'h0};
        m_awaddr = {32'h3000_0000, 32'h0};
        m_wvalid = 2'b10;
        tick();
        checks++; if (s_wvalid !== 1'b1 || s_awvalid !== 1'b0) begin errors++; $display("FAIL wfirst_w_only: got %b%b expected 10", s_wvalid, s_awvalid); end
        tick();
        m_wvalid = 2'b00;
        settle();
        checks++; if (dut.w_done_q !== 1'b1 || s_wvalid !== 1'b0 || m_wready !== 2'b00) begin errors++; $display("FAIL wfirst_w_done: got %b/%b/%b expected 1/0/00", dut.w_done_q, s_wvalid, m_wready); end
        tick();
        checks++; if (dut.state_q !== 2'd1) begin errors++; $display("FAIL wfirst_wait: got %0d expected 1", dut.state_q); end
        m_awvalid = 2'b10;
        settle();
        checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h3000_0000) begin errors++; $display("FAIL wfirst_aw: got %b/%h expected 1/30000000", s_awvalid, s_awaddr); end
        tick();
        m_awvalid = 2'b00;
        settle();
        checks++; if (dut.state_q !== 2'd2) begin errors++; $display("FAIL wfirst_resp: got %0d expected 2", dut.state_q); end
        s_bvalid = 1'b1;
        tick();
        s_bvalid = 1'b0;
        settle();
        checks++; if (wr_count - base != 1) begin errors++; $display("FAIL wfirst_count: got %0d expected 1", wr_count - base); end
    endtask

    task automatic test_bready_hold();
        m_awaddr  = {32'h4000_0004, 32'h4000_0000};
        m_wdata   = {32'h43, 32'h44};
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        m_bready  = 2'b11;
        tick();
        tick();
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        m_bready  = 2'b00;
        s_bresp   = 2'b10;
        s_bvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (m_bvalid !== 2'b01 || m_bresp !== 4'b0010 || s_bready !== 1'b0 || s_awvalid !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d: got %b/%b/%b/%b expected 01/0010/0/0", i, m_bvalid, m_bresp, s_bready, s_awvalid); end
            tick();
        end
        m_bready = 2'b01;
        settle();
        checks++; if (s_bready !== 1'b1) begin errors++; $display("FAIL hold_bready: got %b expected 1", s_bready); end
        tick();
        s_bvalid = 1'b0;
        s_bresp  = 2'b00;
        settle();
        checks++; if (s_awvalid !== 1'b0) begin errors++; $display("FAIL hold_gap: got %b expected 0", s_awvalid); end
        tick();
        checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h4000_0004) begin errors++; $display("FAIL hold_forward: got %b/%h expected 1/40000004", s_awvalid, s_awaddr); end
        tick();
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        m_bready  = 2'b11;
        s_bvalid  = 1'b1;
        tick();
        s_bvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        wq.delete();
        m_wdata   = {32'h61, 32'h51};
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        tick();
        tick();
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        s_bvalid  = 1'b1;
        tick();
        s_bvalid  = 1'b0;
        m_wdata   = {32'h61, 32'h52};
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        tick();
        checks++; if (s_wdata !== 32'h61) begin errors++; $display("FAIL rr_m1_turn: got %h expected 61", s_wdata); end
        tick();
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        s_bvalid  = 1'b1;
        tick();
        s_bvalid = 1'b0;
        tick();
        checks++; if (s_wdata !== 32'h52 || m_wready !== 2'b01) begin errors++; $display("FAIL rr_m0_again: got %h/%b expected 52/01", s_wdata, m_wready); end
        tick();
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        s_bvalid  = 1'b1;
        tick();
        s_bvalid = 1'b0;
        settle();
        checks++; if (wq.size() != 3 || wq[0] !== 32'h51 || wq[1] !== 32'h61 || wq[2] !== 32'h52) begin errors++; $display("FAIL rr_order: got %0d writes expected 51,61,52", wq.size()); end
    endtask

    task automatic test_reset_mid();
        checks++; if (dut.p_q !== 1'b1) begin errors++; $display("FAIL mid_p_before: got %b expected 1", dut.p_q); end
        m_awaddr  = {32'h0, 32'h5000_0000};
        m_awvalid = 2'b01;
        tick();
        tick();
        m_awvalid = 2'b00;
        settle();
        checks++; if (dut.state_q !== 2'd1 || dut.aw_done_q !== 1'b1) begin errors++; $display("FAIL mid_setup: got %0d/%b expected 1/1", dut.state_q, dut.aw_done_q); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_bvalid = 1'b1;
        settle();
        checks++; if (dut.state_q !== 2'd0 || dut.p_q !== 1'b0) begin errors++; $display("FAIL mid_state: got %0d/%b expected 0/0", dut.state_q, dut.p_q); end
        checks++; if ({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, m_bresp} !== 13'd0) begin errors++; $display("FAIL mid_outputs: got %h expected 0", {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, m_bresp}); end
        tick();
        s_bvalid = 1'b0;
        checks++; if (m_bvalid !== 2'b00) begin errors++; $display("FAIL mid_no_resp: got %b expected 00", m_bvalid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_w_first();
        test_bready_hold();
        test_round_robin();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
